// File: rtl/timer_drv_pkg.sv
// timer_drv_pkg: states, timer register map and bus helpers for interval_timer_driver (snap states need TIMER_DRV_SNAPSHOT_EN)
package timer_drv_pkg;
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, GAP, WR_CTRL, RUN, CLR_ST, STOP_WR, STOP_CLR
`ifdef TIMER_DRV_SNAPSHOT_EN
    , SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP
`endif
  } state_t;
  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;
  localparam logic [2:0] SNAPL   = 3'd4;
  localparam logic [2:0] SNAPH   = 3'd5;
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;
  localparam logic [15:0] CTRL_STOP = 16'(1 << STOP);
  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;
  localparam bus_t BUS_IDLE = '{cs: 1'b0, wn: 1'b1, addr: 3'd0, data: 16'h0};
  function automatic logic [15:0] ctrl_word(input logic cont);
    logic [15:0] w;
    w = '0;
    w[ITO] = 1'b1;
    w[START] = 1'b1;
    w[CONT] = cont;
    return w;
  endfunction
  function automatic bus_t wr(input logic [2:0] a, input logic [15:0] d);
    return '{cs: 1'b1, wn: 1'b0, addr: a, data: d};
  endfunction
  function automatic bus_t rd(input logic [2:0] a);
    return '{cs: 1'b1, wn: 1'b1, addr: a, data: 16'h0};
  endfunction
endpackage

// File: rtl/interval_timer_driver.sv
// interval_timer_driver: programs and services the interval timer over Avalon-MM, one tick per timeout (snapshot via TIMER_DRV_SNAPSHOT_EN)
module interval_timer_driver
  import timer_drv_pkg::*;
#(
  parameter int MIN_PERIOD = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      period,
  input  logic             continuous,
  input  logic             stop_req,
  input  logic             snap_req,
  output logic             ready,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             err,
  output logic [31:0]      snapshot,
  output logic             snap_valid,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq
);
  state_t state, state_n;
  bus_t bus, bus_n;
  logic [15:0] per_hi;
  logic cont_q, stop_pend, stop_eff, start_ok;
  assign start_ok = start && period >= 32'(MIN_PERIOD);
  assign stop_eff = stop_pend | stop_req;
  assign ready = state == IDLE;
  assign busy = !ready;
  assign tick = state == CLR_ST;
  assign tmr_chipselect = bus.cs;
  assign tmr_write_n = bus.wn;
  assign tmr_address = bus.addr;
  assign tmr_writedata = bus.data;
`ifdef TIMER_DRV_SNAPSHOT_EN
  logic snap_pend, snap_eff;
  logic [15:0] snap_lo;
  assign snap_eff = snap_pend | snap_req;
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_pend <= 1'b0;
      snap_lo <= '0;
      snapshot <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_pend <= (state_n == IDLE || state_n == SNAP_WR) ? 1'b0 : busy && snap_eff;
      snap_valid <= state == SNAP_CAP;
      if (state == SNAP_RDH) snap_lo <= tmr_readdata;
      if (state == SNAP_CAP) snapshot <= {tmr_readdata, snap_lo};
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{snap_req, tmr_readdata};
  assign snapshot = '0;
  assign snap_valid = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start_ok ? WR_PL : IDLE;
      WR_PL:    state_n = WR_PH;
      WR_PH:    state_n = GAP;
      GAP:      state_n = WR_CTRL;
      WR_CTRL:  state_n = RUN;
`ifdef TIMER_DRV_SNAPSHOT_EN
      RUN:      state_n = tmr_irq ? CLR_ST : stop_eff ? STOP_WR : snap_eff ? SNAP_WR : RUN;
      SNAP_WR:  state_n = SNAP_RDL;
      SNAP_RDL: state_n = SNAP_RDH;
      SNAP_RDH: state_n = SNAP_CAP;
      SNAP_CAP: state_n = RUN;
`else
      RUN:      state_n = tmr_irq ? CLR_ST : stop_eff ? STOP_WR : RUN;
`endif
      CLR_ST:   state_n = cont_q ? RUN : IDLE;
      STOP_WR:  state_n = STOP_CLR;
      STOP_CLR: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // Bus stage is registered from next state so each access lines up with its state.
  always_comb begin
    bus_n = BUS_IDLE;
    case (state_n)
      WR_PL:    bus_n = wr(PERIODL, period[15:0]);
      WR_PH:    bus_n = wr(PERIODH, per_hi);
      WR_CTRL:  bus_n = wr(CONTROL, ctrl_word(cont_q));
      CLR_ST:   bus_n = wr(STATUS, 16'h0);
      STOP_WR:  bus_n = wr(CONTROL, CTRL_STOP);
      STOP_CLR: bus_n = wr(STATUS, 16'h0);
`ifdef TIMER_DRV_SNAPSHOT_EN
      SNAP_WR:  bus_n = wr(SNAPL, 16'h0);
      SNAP_RDL: bus_n = rd(SNAPL);
      SNAP_RDH: bus_n = rd(SNAPH);
`endif
      default:  bus_n = BUS_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus <= BUS_IDLE;
      per_hi <= '0;
      cont_q <= 1'b0;
      stop_pend <= 1'b0;
      tick_count <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      bus <= bus_n;
      err <= ready && start && !start_ok;
      stop_pend <= (state_n == IDLE || state_n == STOP_WR) ? 1'b0 : busy && stop_eff;
      if (ready && start_ok) begin
        per_hi <= period[31:16];
        cont_q <= continuous;
      end
      tick_count <= (ready && start_ok) ? '0 : (state_n == CLR_ST) ? tick_count + CNT_W'(1) : tick_count;
    end
  end
endmodule
